// File: rtl/npc_bpred.sv
// Next-PC generation for a MIPS-style fetch stage, with a 2-bit BHT predictor,
// sticky syscall halt and saturating branch statistics.
module npc_bpred #(
   parameter int          CNT_BITS  = 16,
   parameter int          BHT_DEPTH = 64,
   parameter logic [31:0] HALT_CODE = 32'h0000000a
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [31:0]         IM,
   input  logic [31:0]         OFFSET,
   input  logic [31:0]         PC,
   input  logic [31:0]         RegRS,
   input  logic [31:0]         RegRT,
   output logic [31:0]         NextPC,
   output logic                pred_taken,
   output logic                halted,
   output logic [CNT_BITS-1:0] unconditional,
   output logic [CNT_BITS-1:0] conditional,
   output logic [CNT_BITS-1:0] conditionalsucces,
   output logic [CNT_BITS-1:0] mispredict
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (&v) ? v : v + CNT_BITS'(1);
   endfunction

   function automatic logic [1:0] bht_next(input logic [1:0] e, input logic tk);
      if (tk) return (e == 2'b11) ? e : e + 2'b01;
      else    return (e == 2'b00) ? e : e - 2'b01;
   endfunction

   logic [5:0]        op;
   logic [5:0]        func;
   logic signed [31:0] rs_s;
   logic              is_j, is_jal, is_jr, is_jalr, is_beq, is_bne, is_blez, is_bgtz, is_sys;
   logic              uncond, cond, taken, halt_now, count_en;
   logic [31:0]       pc_plus4, br_target;
   logic [1:0]        bht [BHT_DEPTH];
   logic [IDX_W-1:0]  idx;
   logic [1:0]        bht_rd;

   assign op      = IM[31:26];
   assign func    = IM[5:0];
   assign rs_s    = signed'(RegRS);

   assign is_j    = (op == 6'h02);
   assign is_jal  = (op == 6'h03);
   assign is_jr   = (op == 6'h00) && (func == 6'h08);
   assign is_jalr = (op == 6'h00) && (func == 6'h09);
   assign is_beq  = (op == 6'h04);
   assign is_bne  = (op == 6'h05);
   assign is_blez = (op == 6'h06);
   assign is_bgtz = (op == 6'h07);
   assign is_sys  = (op == 6'h00) && (func == 6'h0c);

   assign uncond  = is_j | is_jal | is_jr | is_jalr;
   assign cond    = is_beq | is_bne | is_blez | is_bgtz;
   assign taken   = (is_beq  && (RegRS == RegRT)) ||
                    (is_bne  && (RegRS != RegRT)) ||
                    (is_blez && (rs_s <= 32'sd0)) ||
                    (is_bgtz && (rs_s >  32'sd0));

   assign halt_now = is_sys && (RegRS == HALT_CODE) && en;
   // The halting syscall itself must not reach any statistic.
   assign count_en = en && !halted && !halt_now;

   assign idx        = PC[IDX_W+1:2];
   assign bht_rd     = bht[idx];
   assign pred_taken = cond && bht_rd[1];

   assign pc_plus4  = PC + 32'd4;
   assign br_target = pc_plus4 + (OFFSET << 2);

   always_comb begin
      NextPC = pc_plus4;
      if (halted || halt_now)  NextPC = PC;
      else if (is_jr || is_jalr) NextPC = RegRS;
      else if (is_j || is_jal) NextPC = {PC[31:28], IM[25:0], 2'b00};
      else if (cond && taken)  NextPC = br_target;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         halted            <= 1'b0;
         unconditional     <= '0;
         conditional       <= '0;
         conditionalsucces <= '0;
         mispredict        <= '0;
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      end else begin
         if (halt_now) halted <= 1'b1;
         if (count_en) begin
            if (uncond) unconditional <= sat_inc(unconditional);
            if (cond) begin
               conditional <= sat_inc(conditional);
               bht[idx]    <= bht_next(bht_rd, taken);
               if (taken)               conditionalsucces <= sat_inc(conditionalsucces);
               if (pred_taken != taken) mispredict        <= sat_inc(mispredict);
            end
         end
      end
   end

endmodule
